// File: rtl/md_pkg.sv
// ============================================================================
// md_pkg : shared encodings, default latencies and state type for the
//          multiply/divide issue controller.
// Rev 1.0
// ============================================================================
`default_nettype none

package md_pkg;

  localparam logic [1:0] MD_MULTU  = 2'd0;
  localparam logic [1:0] MD_DIVU   = 2'd1;
  localparam logic [1:0] MD_MULT   = 2'd2;
  localparam logic [1:0] MD_DIV    = 2'd3;

  localparam logic [1:0] MDWE_NONE = 2'd0;
  localparam logic [1:0] MDWE_HI   = 2'd1;
  localparam logic [1:0] MDWE_LO   = 2'd2;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // Bit 0 of the op code separates divides from multiplies.
  function automatic logic md_is_div(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_busy_counter.sv
// ============================================================================
// md_busy_counter : loadable down-counter mirroring the MULDIV busy timer.
// Rev 1.0
// ============================================================================
`default_nettype none

module md_busy_counter
  import md_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             zero
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = BUSY;
      cnt_d   = load_val;
    end else if (state_q == BUSY) begin
      // The last busy cycle returns straight to IDLE so a new op can issue.
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (state_q == BUSY);
  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/md_issue_ctrl.sv
// ============================================================================
// md_issue_ctrl : E-stage issuer and HI/LO interlock for the MULDIV unit.
// Optional macro MD_STALL_STAT_EN adds stall_cycles / issue_count counters.
// Rev 1.0
// ============================================================================
`default_nettype none

module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_valid,
  input  logic             e_md_req,
  input  logic [1:0]       e_md_op,
  input  logic [1:0]       e_md_we,
  input  logic             flush,
  input  logic             d_is_md,
  output logic             start,
  output logic [1:0]       mdop,
  output logic [1:0]       mdwe,
  output logic             busy,
  output logic             stall_d,
`ifdef MD_STALL_STAT_EN
  output logic [31:0]      stall_cycles,
  output logic [31:0]      issue_count,
`endif
  output logic [CNT_W-1:0] cnt
);

  logic             idle;
  logic             cnt_zero;
  logic             issue;
  logic             we_ok;
  logic [CNT_W-1:0] load_val;

  md_busy_counter #(
    .CNT_W (CNT_W)
  ) u_busy_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (issue),
    .load_val (load_val),
    .cnt      (cnt),
    .busy     (busy),
    .zero     (cnt_zero)
  );

  assign idle     = ~busy & cnt_zero;
  assign issue    = e_valid & e_md_req & ~flush & idle;
  assign load_val = md_is_div(e_md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

  // Only the HI and LO selects reach the unit; encoding 3 collapses to none.
  assign we_ok    = (e_md_we == MDWE_HI) || (e_md_we == MDWE_LO);

  assign start    = issue;
  assign mdop     = issue ? e_md_op : MD_MULTU;
  assign mdwe     = (e_valid & ~flush & ~e_md_req & idle & we_ok) ? e_md_we : MDWE_NONE;
  assign stall_d  = d_is_md & (busy | start);

`ifdef MD_STALL_STAT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] issue_count_q,  issue_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    issue_count_d  = issue_count_q;
    if (stall_d && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
    if (start   && (issue_count_q  != 32'hFFFF_FFFF)) issue_count_d  = issue_count_q  + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      issue_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      issue_count_q  <= issue_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign issue_count  = issue_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
// ============================================================================
// tb_md_issue_ctrl : scoreboard bench for md_issue_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_md_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       e_valid, e_md_req, flush, d_is_md;
  logic [1:0] e_md_op, e_md_we;
  logic       start, busy, stall_d;
  logic [1:0] mdop, mdwe;
  logic [4:0] cnt;
`ifdef MD_STALL_STAT_EN
  logic [31:0] stall_cycles, issue_count;
`endif

  md_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .e_valid      (e_valid),
    .e_md_req     (e_md_req),
    .e_md_op      (e_md_op),
    .e_md_we      (e_md_we),
    .flush        (flush),
    .d_is_md      (d_is_md),
    .start        (start),
    .mdop         (mdop),
    .mdwe         (mdwe),
    .busy         (busy),
    .stall_d      (stall_d),
`ifdef MD_STALL_STAT_EN
    .stall_cycles (stall_cycles),
    .issue_count  (issue_count),
`endif
    .cnt          (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [1:0] mdop;
    logic [1:0] mdwe;
    logic       busy;
    logic       stall;
    logic [4:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_cnt    = 0;
  int   m_stall  = 0;
  int   m_issue  = 0;
  logic act_start, act_stall, act_busy;
  logic [1:0] act_mdwe;

  // Scoreboard checker: one expected entry per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (start !== e.start)  begin n_errors++; $display("FAIL sb_start got=%b exp=%b t=%0t", start, e.start, $time); end
      n_checks++;
      if (mdop !== e.mdop)    begin n_errors++; $display("FAIL sb_mdop got=%0d exp=%0d t=%0t", mdop, e.mdop, $time); end
      n_checks++;
      if (mdwe !== e.mdwe)    begin n_errors++; $display("FAIL sb_mdwe got=%0d exp=%0d t=%0t", mdwe, e.mdwe, $time); end
      n_checks++;
      if (busy !== e.busy)    begin n_errors++; $display("FAIL sb_busy got=%b exp=%b t=%0t", busy, e.busy, $time); end
      n_checks++;
      if (stall_d !== e.stall) begin n_errors++; $display("FAIL sb_stall got=%b exp=%b t=%0t", stall_d, e.stall, $time); end
      n_checks++;
      if (cnt !== e.cnt)      begin n_errors++; $display("FAIL sb_cnt got=%0d exp=%0d t=%0t", cnt, e.cnt, $time); end
    end
  end

  // Drives one cycle (entered at posedge+1), pushes the model's expectation,
  // then advances the reference model across the clock edge.
  task automatic cycle(input logic ev, input logic req, input logic [1:0] op,
                       input logic [1:0] we, input logic fl, input logic dmd);
    exp_t e;
    logic mb, iss;
    e_valid = ev; e_md_req = req; e_md_op = op; e_md_we = we; flush = fl; d_is_md = dmd;
    mb  = (m_cnt != 0);
    iss = ev & req & ~fl & ~mb;
    e.start = iss;
    e.mdop  = iss ? op : 2'd0;
    e.mdwe  = (ev & ~fl & ~req & ~mb & ((we == 2'd1) || (we == 2'd2))) ? we : 2'd0;
    e.busy  = mb;
    e.stall = dmd & (mb | iss);
    e.cnt   = 5'(m_cnt);
    sb.push_back(e);
    @(negedge clk);
    act_start = start; act_stall = stall_d; act_busy = busy; act_mdwe = mdwe;
    @(posedge clk); #1;
    if (e.stall) m_stall++;
    if (iss)     m_issue++;
    if (iss)             m_cnt = op[0] ? 10 : 5;
    else if (m_cnt > 0)  m_cnt = m_cnt - 1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    e_valid = 0; e_md_req = 0; e_md_op = 0; e_md_we = 0; flush = 0; d_is_md = 0;
    #12;
    n_checks++;
    if ({start, mdop, mdwe, busy, stall_d, cnt} !== 12'd0) begin
      n_errors++; $display("FAIL reset_outputs got=%h exp=0", {start, mdop, mdwe, busy, stall_d, cnt});
    end
`ifdef MD_STALL_STAT_EN
    n_checks++;
    if ((stall_cycles !== 32'd0) || (issue_count !== 32'd0)) begin
      n_errors++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stall_cycles, issue_count);
    end
`endif
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    m_cnt = 0; m_stall = 0; m_issue = 0;
  endtask

  task automatic test_mult;
    cycle(1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if (act_start !== 1'b1) begin n_errors++; $display("FAIL mult_start got=%b exp=1", act_start); end
    for (int i = 5; i >= 1; i--) begin
      n_checks++;
      if (cnt !== 5'(i)) begin n_errors++; $display("FAIL mult_cnt got=%0d exp=%0d", cnt, i); end
      cycle(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    end
    n_checks++;
    if ((cnt !== 5'd0) || (busy !== 1'b0)) begin
      n_errors++; $display("FAIL mult_done cnt=%0d busy=%b exp=0/0", cnt, busy);
    end
    idle_cycles(1);
  endtask

  task automatic test_div_stall;
    int nstall = 0;
    int run    = 0;
    for (int i = 0; i < 13; i++) begin
      cycle(i == 0, i == 0, 2'd1, 2'd0, 1'b0, 1'b1);
      if (act_stall) begin nstall++; if (run == i) run++; end
    end
    n_checks++;
    if ((nstall !== 11) || (run !== 11)) begin
      n_errors++; $display("FAIL div_stall_len got=%0d run=%0d exp=11", nstall, run);
    end
  endtask

  task automatic test_flush;
    cycle(1'b1, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0);
    n_checks++;
    if ((act_start !== 1'b0) || (busy !== 1'b0) || (cnt !== 5'd0)) begin
      n_errors++; $display("FAIL flush_issue start=%b busy=%b cnt=%0d exp=0/0/0", act_start, busy, cnt);
    end
    cycle(1'b1, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
    idle_cycles(1);
  endtask

  task automatic test_conflict;
    cycle(1'b1, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0);
    n_checks++;
    if ((act_start !== 1'b1) || (act_mdwe !== 2'd0)) begin
      n_errors++; $display("FAIL conflict_issue start=%b mdwe=%0d exp=1/0", act_start, act_mdwe);
    end
    cycle(1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0);
    n_checks++;
    if ((act_busy !== 1'b1) || (act_mdwe !== 2'd0)) begin
      n_errors++; $display("FAIL conflict_busy_we busy=%b mdwe=%0d exp=1/0", act_busy, act_mdwe);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 2'd3, 2'd1, 1'b0, 1'b0);
  endtask

  task automatic test_mtlo;
    idle_cycles(1);
    cycle(1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0);
    n_checks++;
    if ((act_mdwe !== 2'd2) || (act_start !== 1'b0) || (act_busy !== 1'b0)) begin
      n_errors++; $display("FAIL mtlo mdwe=%0d start=%b busy=%b exp=2/0/0", act_mdwe, act_start, act_busy);
    end
    cycle(1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    cycle(1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) cycle(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1);
    n_checks++;
    if (act_start !== 1'b1) begin n_errors++; $display("FAIL b2b_reissue got=%b exp=1", act_start); end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
`ifdef MD_STALL_STAT_EN
    n_checks++;
    if ((stall_cycles !== 32'(m_stall)) || (issue_count !== 32'(m_issue))) begin
      n_errors++; $display("FAIL stats got=%0d/%0d exp=%0d/%0d", stall_cycles, issue_count, m_stall, m_issue);
    end
`endif
  endtask

  task automatic test_reset_mid;
    cycle(1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if ((cnt !== 5'd7) || (stall_d !== 1'b1)) begin
      n_errors++; $display("FAIL rst_mid_pre cnt=%0d stall=%b exp=7/1", cnt, stall_d);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ((busy !== 1'b0) || (cnt !== 5'd0) || (stall_d !== 1'b0)) begin
      n_errors++; $display("FAIL rst_mid busy=%b cnt=%0d stall=%b exp=0/0/0", busy, cnt, stall_d);
    end
`ifdef MD_STALL_STAT_EN
    n_checks++;
    if (stall_cycles !== 32'd0) begin
      n_errors++; $display("FAIL rst_mid_stats got=%0d exp=0", stall_cycles);
    end
`endif
    @(negedge clk); reset = 1'b0; d_is_md = 1'b0;
    @(posedge clk); #1;
    m_cnt = 0; m_stall = 0; m_issue = 0;
    cycle(1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0);
    idle_cycles(6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_mult;
    test_div_stall;
    test_flush;
    test_conflict;
    test_mtlo;
    test_back_to_back;
    test_reset_mid;
    n_checks++;
    if (sb.size() != 0) begin n_errors++; $display("FAIL sb_drain left=%0d exp=0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
